// File: rtl/video_src_sched.sv
// video_src_sched: frame-synchronous source scheduler for the display video path.
// It selects between the camera stream and the colour-bar test pattern, switches only
// on vsync rising edges, and drops to a safe state when the chosen source stops
// producing frames.
// Optional build macro: FRAME_CNT_EN adds a 16-bit count of forwarded frames on
// o_frame_cnt. Without it, o_frame_cnt is tied to zero.
module video_src_sched #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000,
  parameter int          TCW         = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_src_sel,
  output logic        o_cam_en,
  output logic        o_tpg_en,
  input  logic        i_cam_hs,
  input  logic        i_cam_vs,
  input  logic        i_cam_de,
  input  logic [7:0]  i_cam_data,
  input  logic        i_tpg_hs,
  input  logic        i_tpg_vs,
  input  logic        i_tpg_de,
  input  logic [7:0]  i_tpg_data,
  output logic        o_out_hs,
  output logic        o_out_vs,
  output logic        o_out_de,
  output logic [7:0]  o_out_data,
  output logic [1:0]  o_active_src,
  output logic        o_busy,
  output logic        o_fault,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT,
    S_RUN,
    S_DRAIN,
    S_FAULT
  } state_t;

  // The watchdog stops at this value, so it can never wrap back to zero.
  localparam logic [TCW-1:0] WD_LAST = TCW'(TIMEOUT_CYC - 24'd1);

  state_t         r_state;
  state_t         w_next_state;
  logic [1:0]     r_target;
  logic [1:0]     w_next_target;
  logic           r_wait_new;
  logic           w_next_wait_new;
  logic [TCW-1:0] r_wdog;
  logic [TCW-1:0] w_next_wdog;
  logic [TCW-1:0] w_wdog_inc;
  logic           r_cam_vs_q;
  logic           r_tpg_vs_q;
  logic           w_cam_fs;
  logic           w_tpg_fs;
  logic           w_tgt_fs;
  logic           w_timeout;
  logic           w_sel_valid;
  logic           w_src_on;
  logic [1:0]     w_fwd_src;
  logic           r_out_hs;
  logic           r_out_vs;
  logic           r_out_de;
  logic [7:0]     r_out_data;
  logic [1:0]     r_active;

  assign w_cam_fs    = i_cam_vs & ~r_cam_vs_q;
  assign w_tpg_fs    = i_tpg_vs & ~r_tpg_vs_q;
  assign w_tgt_fs    = (r_target == 2'd1) ? w_cam_fs :
                       (r_target == 2'd2) ? w_tpg_fs : 1'b0;
  assign w_timeout   = (r_wdog == WD_LAST);
  assign w_wdog_inc  = w_timeout ? r_wdog : r_wdog + TCW'(1);
  assign w_sel_valid = (i_src_sel == 2'd1) || (i_src_sel == 2'd2);

  // One-cycle copies of both vsyncs for rising-edge detection; no reset needed.
  always_ff @(posedge i_clk) begin
    r_cam_vs_q <= i_cam_vs;
    r_tpg_vs_q <= i_tpg_vs;
  end

  // State, target, first-WAIT-cycle flag and watchdog registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_OFF;
      r_target   <= 2'd0;
      r_wait_new <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_target   <= w_next_target;
      r_wait_new <= w_next_wait_new;
      r_wdog     <= w_next_wdog;
    end
  end

  // Next-state logic. The first WAIT cycle after a (re)target keeps enables low,
  // which guarantees a gap of at least one cycle between the two sources.
  always_comb begin
    w_next_state    = r_state;
    w_next_target   = r_target;
    w_next_wait_new = 1'b0;
    w_next_wdog     = w_wdog_inc;
    case (r_state)
      S_OFF: begin
        w_next_wdog = '0;
        if (w_sel_valid) begin
          w_next_state    = S_WAIT;
          w_next_target   = i_src_sel;
          w_next_wait_new = 1'b1;
        end
      end
      S_WAIT: begin
        if (!w_sel_valid) begin
          w_next_state = S_OFF;
          w_next_wdog  = '0;
        end else if (i_src_sel != r_target) begin
          w_next_target   = i_src_sel;
          w_next_wait_new = 1'b1;
          w_next_wdog     = '0;
        end else if (w_tgt_fs && !r_wait_new) begin
          w_next_state = S_RUN;
          w_next_wdog  = '0;
        end else if (w_timeout) begin
          w_next_state = S_FAULT;
        end
      end
      S_RUN: begin
        if (w_tgt_fs) begin
          w_next_wdog = '0;
        end
        if (w_timeout && !w_tgt_fs) begin
          w_next_state = S_FAULT;
        end else if (i_src_sel != r_target) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_src_sel == r_target) begin
          w_next_state = S_RUN;
          if (w_tgt_fs) begin
            w_next_wdog = '0;
          end
        end else if (w_tgt_fs || w_timeout) begin
          w_next_wdog = '0;
          if (w_sel_valid) begin
            w_next_state    = S_WAIT;
            w_next_target   = i_src_sel;
            w_next_wait_new = 1'b1;
          end else begin
            w_next_state = S_OFF;
          end
        end
      end
      S_FAULT: begin
        w_next_wdog = '0;
        if (!w_sel_valid) begin
          w_next_state = S_OFF;
        end
      end
      default: begin
        w_next_state = S_OFF;
        w_next_wdog  = '0;
      end
    endcase
  end

  // A source is forwarded only when the next state is RUN or DRAIN. This drops
  // the closing vsync edge of a drain and admits the opening edge of a new frame.
  assign w_fwd_src = ((w_next_state == S_RUN) || (w_next_state == S_DRAIN)) ? r_target : 2'd0;

  // Registered output mux, which gives one clock of latency from the chosen source.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_hs   <= 1'b0;
      r_out_vs   <= 1'b0;
      r_out_de   <= 1'b0;
      r_out_data <= 8'd0;
      r_active   <= 2'd0;
    end else begin
      case (w_fwd_src)
        2'd1: begin
          r_out_hs   <= i_cam_hs;
          r_out_vs   <= i_cam_vs;
          r_out_de   <= i_cam_de;
          r_out_data <= i_cam_data;
        end
        2'd2: begin
          r_out_hs   <= i_tpg_hs;
          r_out_vs   <= i_tpg_vs;
          r_out_de   <= i_tpg_de;
          r_out_data <= i_tpg_data;
        end
        default: begin
          r_out_hs   <= 1'b0;
          r_out_vs   <= 1'b0;
          r_out_de   <= 1'b0;
          r_out_data <= 8'd0;
        end
      endcase
      r_active <= w_fwd_src;
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count each forwarded frame start. The counter wraps naturally and clears only on reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if ((w_fwd_src != 2'd0) && w_tgt_fs) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`else
  assign o_frame_cnt = 16'd0;
`endif

  assign w_src_on     = (r_state == S_RUN) || (r_state == S_DRAIN) ||
                        ((r_state == S_WAIT) && !r_wait_new);
  assign o_cam_en     = w_src_on && (r_target == 2'd1);
  assign o_tpg_en     = w_src_on && (r_target == 2'd2);
  assign o_busy       = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign o_fault      = (r_state == S_FAULT);
  assign o_out_hs     = r_out_hs;
  assign o_out_vs     = r_out_vs;
  assign o_out_de     = r_out_de;
  assign o_out_data   = r_out_data;
  assign o_active_src = r_active;

endmodule

// File: tb/tb_video_src_sched.sv
// Testbench for video_src_sched. It uses free-running camera and test-pattern sources
// with random pixel data and random source requests. A timestamp-based reference
// model predicts every output on every cycle.
module tb_video_src_sched;

  localparam logic [23:0] TMO   = 24'd1000;
  localparam int          T     = 1000;
  localparam int          TPG_P = 600;
  localparam int          CAM_P = 800;
  localparam int M_OFF = 0, M_WAIT = 1, M_RUN = 2, M_DRAIN = 3, M_FAULT = 4;

  logic        clk;
  logic        rstN;
  logic [1:0]  srcSel;
  logic        camHs, camVs, camDe, tpgHs, tpgVs, tpgDe;
  logic [7:0]  camData, tpgData;
  logic        camEn, tpgEn, outHs, outVs, outDe, busy, fault;
  logic [7:0]  outData;
  logic [1:0]  activeSrc;
  logic [15:0] frameCnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tpgPos = 100;
  int camPos = 400;
  bit camStall = 0;

  // Reference model state. mClr is the cycle of the last watchdog restart, and
  // mWaitFrom is the first cycle of the latest WAIT entry.
  int          mMode     = M_OFF;
  int          mTarget   = 0;
  int          mClr      = -1;
  int          mWaitFrom = 0;
  logic        mCamVsPrev = 1'b0;
  logic        mTpgVsPrev = 1'b0;
  logic [15:0] mFcnt     = 16'd0;
  logic        eHs = 1'b0, eVs = 1'b0, eDe = 1'b0;
  logic [7:0]  eData = 8'd0;
  logic [1:0]  eActive = 2'd0;

  video_src_sched #(.TIMEOUT_CYC(TMO), .TCW(24)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_src_sel(srcSel),
    .o_cam_en(camEn), .o_tpg_en(tpgEn),
    .i_cam_hs(camHs), .i_cam_vs(camVs), .i_cam_de(camDe), .i_cam_data(camData),
    .i_tpg_hs(tpgHs), .i_tpg_vs(tpgVs), .i_tpg_de(tpgDe), .i_tpg_data(tpgData),
    .o_out_hs(outHs), .o_out_vs(outVs), .o_out_de(outDe), .o_out_data(outData),
    .o_active_src(activeSrc), .o_busy(busy), .o_fault(fault), .o_frame_cnt(frameCnt)
  );

  // Free-running pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the reference model across one rising edge, using the inputs present at that edge.
  task automatic modelStep();
    bit fsCam, fsTpg, tgtFs, tmo, armed, selOk;
    int fwd, sel;
    sel   = int'(srcSel);
    fsCam = camVs && !mCamVsPrev;
    fsTpg = tpgVs && !mTpgVsPrev;
    tgtFs = (mTarget == 1) ? fsCam : (mTarget == 2) ? fsTpg : 1'b0;
    tmo   = (cyc - mClr) >= T;
    armed = cyc > mWaitFrom;
    selOk = (sel == 1) || (sel == 2);
    fwd   = 0;
    if (!rstN) begin
      mMode = M_OFF; mTarget = 0; mClr = cyc; mFcnt = 16'd0;
    end else begin
      case (mMode)
        M_OFF: begin
          mClr = cyc;
          if (selOk) begin mMode = M_WAIT; mTarget = sel; mWaitFrom = cyc + 1; end
        end
        M_WAIT: begin
          if (!selOk) begin mMode = M_OFF; mClr = cyc; end
          else if (sel != mTarget) begin mTarget = sel; mWaitFrom = cyc + 1; mClr = cyc; end
          else if (tgtFs && armed) begin mMode = M_RUN; mClr = cyc; fwd = mTarget; end
          else if (tmo) mMode = M_FAULT;
        end
        M_RUN: begin
          if (tgtFs) mClr = cyc;
          if (tmo && !tgtFs) mMode = M_FAULT;
          else begin
            if (sel != mTarget) mMode = M_DRAIN;
            fwd = mTarget;
          end
        end
        M_DRAIN: begin
          if (sel == mTarget) begin
            mMode = M_RUN; fwd = mTarget;
            if (tgtFs) mClr = cyc;
          end else if (tgtFs || tmo) begin
            mClr = cyc;
            if (selOk) begin mMode = M_WAIT; mTarget = sel; mWaitFrom = cyc + 1; end
            else mMode = M_OFF;
          end else fwd = mTarget;
        end
        default: begin
          mClr = cyc;
          if (!selOk) mMode = M_OFF;
        end
      endcase
      if (fwd != 0 && tgtFs) mFcnt = mFcnt + 16'd1;
    end
    eActive = 2'(fwd);
    eHs = (fwd == 1) ? camHs : (fwd == 2) ? tpgHs : 1'b0;
    eVs = (fwd == 1) ? camVs : (fwd == 2) ? tpgVs : 1'b0;
    eDe = (fwd == 1) ? camDe : (fwd == 2) ? tpgDe : 1'b0;
    eData = (fwd == 1) ? camData : (fwd == 2) ? tpgData : 8'd0;
    mCamVsPrev = camVs;
    mTpgVsPrev = tpgVs;
    cyc++;
  endtask

  task automatic checkOutput();
    bit on;
    logic [15:0] eFcnt;
    on = (mMode == M_RUN) || (mMode == M_DRAIN) || ((mMode == M_WAIT) && (cyc > mWaitFrom));
`ifdef FRAME_CNT_EN
    eFcnt = mFcnt;
`else
    eFcnt = 16'd0;
`endif
    chk("cam_en", 16'(camEn), 16'(on && mTarget == 1));
    chk("tpg_en", 16'(tpgEn), 16'(on && mTarget == 2));
    chk("en_exclusive", 16'(camEn & tpgEn), 16'd0);
    chk("out_hs", 16'(outHs), 16'(eHs));
    chk("out_vs", 16'(outVs), 16'(eVs));
    chk("out_de", 16'(outDe), 16'(eDe));
    chk("out_data", 16'(outData), 16'(eData));
    chk("active_src", 16'(activeSrc), 16'(eActive));
    chk("busy", 16'(busy), 16'(mMode == M_WAIT || mMode == M_DRAIN));
    chk("fault", 16'(fault), 16'(mMode == M_FAULT));
    chk("frame_cnt", frameCnt, eFcnt);
  endtask

  // Drive one cycle of source timing on the falling edge, step the model at the
  // rising edge, and check the outputs just after it.
  task automatic applyStimulus();
    @(negedge clk);
    tpgPos  = (tpgPos + 1) % TPG_P;
    tpgVs   = (tpgPos < 3);
    tpgHs   = (tpgPos % 50) < 5;
    tpgDe   = (tpgPos >= 30) && ((tpgPos % 50) >= 10);
    tpgData = 8'($urandom);
    camPos  = (camPos + 1) % CAM_P;
    camVs   = !camStall && (camPos < 4);
    camHs   = (camPos % 64) < 6;
    camDe   = (camPos >= 40) && ((camPos % 64) >= 12);
    camData = 8'($urandom);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    rstN = 1'b0; srcSel = 2'd0;
    camHs = 0; camVs = 0; camDe = 0; camData = 0;
    tpgHs = 0; tpgVs = 0; tpgDe = 0; tpgData = 0;

    $display("[TB] reset");
    repeat (4) applyStimulus();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_active", 16'(activeSrc), 16'd0);
    rstN = 1'b1;
    repeat (2) applyStimulus();

    $display("[TB] select test pattern");
    srcSel = 2'd2;
    applyStimulus();
    chk("t1_wait1_en", 16'(tpgEn), 16'd0);
    applyStimulus();
    chk("t1_wait2_en", 16'(tpgEn), 16'd1);
    for (int k = 0; k < 1000 && eActive != 2'd2; k++) applyStimulus();
    chk("t1_active", 16'(activeSrc), 16'd2);
    chk("t1_first_vs", 16'(outVs), 16'd1);

    $display("[TB] switch to camera mid-frame");
    repeat (200) applyStimulus();
    srcSel = 2'd1;
    for (int k = 0; k < 800 && (mMode != M_WAIT); k++) applyStimulus();
    chk("t2_gap_cam", 16'(camEn), 16'd0);
    chk("t2_gap_tpg", 16'(tpgEn), 16'd0);
    chk("t2_gap_out", 16'(outDe | outVs), 16'd0);
    for (int k = 0; k < 1200 && eActive != 2'd1; k++) applyStimulus();
    chk("t2_cam_active", 16'(activeSrc), 16'd1);
    chk("t2_cam_first_vs", 16'(outVs), 16'd1);
    repeat (300) applyStimulus();

    $display("[TB] random source requests");
    for (int r = 0; r < 10; r++) begin
      srcSel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(50, 900)) applyStimulus();
    end
    srcSel = 2'd0;
    repeat (3) applyStimulus();

    $display("[TB] camera never starts");
    camStall = 1'b1;
    srcSel = 2'd1;
    for (int k = 0; k < 1100 && mMode != M_FAULT; k++) applyStimulus();
    chk("t3_fault", 16'(fault), 16'd1);
    chk("t3_cam_en", 16'(camEn), 16'd0);
    srcSel = 2'd0;
    repeat (2) applyStimulus();
    chk("t3_fault_clear", 16'(fault), 16'd0);
    chk("t3_busy", 16'(busy), 16'd0);

    $display("[TB] camera stalls while running");
    camStall = 1'b0;
    srcSel = 2'd1;
    for (int k = 0; k < 2000 && eActive != 2'd1; k++) applyStimulus();
    repeat (300) applyStimulus();
    camStall = 1'b1;
    for (int k = 0; k < 2000 && mMode != M_FAULT; k++) applyStimulus();
    chk("t4_fault", 16'(fault), 16'd1);
    chk("t4_out_de", 16'(outDe | outHs | outVs), 16'd0);
    chk("t4_active", 16'(activeSrc), 16'd0);
    camStall = 1'b0;
    srcSel = 2'd0;
    repeat (2) applyStimulus();

    $display("[TB] reset mid-frame");
    srcSel = 2'd2;
    for (int k = 0; k < 1500 && eActive != 2'd2; k++) applyStimulus();
    repeat (100) applyStimulus();
    rstN = 1'b0;
    applyStimulus();
    chk("t5_tpg_en", 16'(tpgEn), 16'd0);
    chk("t5_active", 16'(activeSrc), 16'd0);
    chk("t5_out", 16'(outDe | outHs | outVs), 16'd0);
    chk("t5_frame_cnt", frameCnt, 16'd0);
    rstN = 1'b1;
    srcSel = 2'd0;
    repeat (2) applyStimulus();

`ifdef FRAME_CNT_EN
    $display("[TB] frame counter");
    srcSel = 2'd2;
    for (int k = 0; k < 2500 && mFcnt != 16'd3; k++) applyStimulus();
    applyStimulus();
    chk("t6_three", frameCnt, 16'd3);
    mFcnt = 16'hFFFF;
    force dut.r_frame_cnt = 16'hFFFF;
    applyStimulus();
    release dut.r_frame_cnt;
    for (int k = 0; k < 800 && mFcnt == 16'hFFFF; k++) applyStimulus();
    chk("t6_wrap", frameCnt, 16'd0);
    srcSel = 2'd0;
    repeat (2) applyStimulus();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
